latch_capture: RTL and testbench

LATCH_CAPTURE -- requirements
Module: latch_capture

---
 rtl/latch_capture.sv | 102 ++++++++++
 tb/tb_latch_capture.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/latch_capture.sv
// Synchronizes and debounces the level from an upstream latch, queueing each
// accepted level change with a timestamp in a small first-word-fall-through FIFO.
module latch_capture #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int DEPTH         = 4,
   parameter int TS_W          = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            d_in,
   input  logic            out_ready,
   output logic            out_valid,
   output logic            out_level,
   output logic [TS_W-1:0] out_stamp,
   output logic [7:0]      glitch_cnt,
   output logic            fifo_full,
   output logic            overflow
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_q;
   logic [TS_W-1:0]        ts;
   logic                   ts_run;
   logic                   stable;
   logic [3:0]             cnt;
   logic                   push, do_push, pop;
   logic [TS_W:0]          mem [DEPTH];
   logic [TS_W:0]          head;
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [AW:0]            occ;

   assign sync_q = sync_r[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!reset) sync_r <= '0;
      else        sync_r <= {sync_r[SYNC_STAGES-2:0], d_in};
   end

   // ts reads 0 through the first released edge, so that edge counts as ts=0
   always_ff @(posedge clk) begin
      if (!reset) begin
         ts     <= '0;
         ts_run <= 1'b0;
      end else begin
         ts_run <= 1'b1;
         if (ts_run) ts <= ts + TS_W'(1);
      end
   end

   assign push = (sync_q != stable) && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         stable     <= 1'b0;
         cnt        <= '0;
         glitch_cnt <= '0;
      end else if (sync_q != stable) begin
         if (cnt == CNT_LAST) begin
            stable <= sync_q;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end else if (cnt != '0) begin
         cnt <= '0;
         if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
      end
   end

   assign pop     = out_valid && out_ready;
   assign do_push = push && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !pop)      occ <= occ + (AW+1)'(1);
         else if (!do_push && pop) occ <= occ - (AW+1)'(1);
         if (push && !do_push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && do_push) mem[wr_ptr] <= {sync_q, ts};
   end

   assign head      = mem[rd_ptr];
   assign out_valid = (occ != '0);
   assign fifo_full = (occ == (AW+1)'(DEPTH));
   assign out_level = out_valid & head[TS_W];
   assign out_stamp = out_valid ? head[TS_W-1:0] : '0;

endmodule

// File: tb/tb_latch_capture.sv
// Scoreboard bench for latch_capture at default parameters: expected events are
// queued when d_in is driven and compared as the consumer pops them.
module tb_latch_capture;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       d_in = 1'b0;
   logic       out_ready = 1'b0;
   logic       out_valid, out_level, fifo_full, overflow;
   logic [7:0] out_stamp, glitch_cnt;

   int         n_tot = 0;
   int         n_bad = 0;
   int         e;
   logic [8:0] sb [$];
   logic [8:0] mon_exp;

   latch_capture dut (
      .clk(clk), .reset(reset), .d_in(d_in), .out_ready(out_ready),
      .out_valid(out_valid), .out_level(out_level), .out_stamp(out_stamp),
      .glitch_cnt(glitch_cnt), .fifo_full(fifo_full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // index of the next edge, counted from the first edge with reset released
   always @(posedge clk) begin
      if (!reset) e <= 0;
      else        e <= e + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // commit lands 5 edges after the next one; stamp is ts before that edge
   task automatic toggle(input logic lvl, input bit kept);
      d_in = lvl;
      if (kept) sb.push_back({lvl, 8'(e + 4)});
      step(8);
   endtask

   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_evt", {out_level, out_stamp}, 9'h1FF);
         end else begin
            mon_exp = sb.pop_front();
            chk("evt_level", out_level, mon_exp[8]);
            chk("evt_stamp", out_stamp, mon_exp[7:0]);
         end
      end
   end

   initial begin
      step(3);
      chk("rst_valid", out_valid, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_level", out_level, 0);
      chk("rst_stamp", out_stamp, 0);
      chk("rst_glitch", glitch_cnt, 0);
      chk("rst_ovf", overflow, 0);

      // basic rise: change before edge 0, written at edge 5 with stamp 4
      out_ready = 1'b1;
      reset = 1'b1;
      d_in = 1'b1;
      sb.push_back({1'b1, 8'd4});
      step(5);
      chk("rise_early", out_valid, 0);
      step(1);
      chk("rise_valid", out_valid, 1);
      chk("rise_level", out_level, 1);
      chk("rise_stamp", out_stamp, 4);
      step(1);
      chk("rise_popped", out_valid, 0);
      chk("rise_glitch", glitch_cnt, 0);
      step(2);

      // glitch: two-cycle pulse is rejected
      toggle(1'b0, 1'b1);
      d_in = 1'b1;
      step(2);
      d_in = 1'b0;
      step(8);
      chk("glitch_cnt", glitch_cnt, 1);
      chk("glitch_stable", dut.stable, 0);
      chk("glitch_noevt", out_valid, 0);

      // push and pop on the same edge while full
      out_ready = 1'b0;
      toggle(1'b1, 1'b1);
      toggle(1'b0, 1'b1);
      toggle(1'b1, 1'b1);
      toggle(1'b0, 1'b1);
      chk("pp_full_pre", fifo_full, 1);
      chk("pp_ovf_pre", overflow, 0);
      d_in = 1'b1;
      sb.push_back({1'b1, 8'(e + 4)});
      step(5);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      chk("pp_ovf", overflow, 0);
      chk("pp_full", fifo_full, 1);
      out_ready = 1'b1;
      step(6);
      chk("pp_drained", out_valid, 0);
      toggle(1'b0, 1'b1);

      // overflow: fifth event dropped while the consumer stalls
      out_ready = 1'b0;
      toggle(1'b1, 1'b1);
      toggle(1'b0, 1'b1);
      toggle(1'b1, 1'b1);
      toggle(1'b0, 1'b1);
      chk("ovf_full4", fifo_full, 1);
      chk("ovf_pre", overflow, 0);
      toggle(1'b1, 1'b0);
      chk("ovf_set", overflow, 1);
      chk("ovf_full5", fifo_full, 1);
      out_ready = 1'b1;
      step(6);
      chk("ovf_drained", out_valid, 0);
      chk("ovf_sticky", overflow, 1);

      // timestamp wrap: commit when ts=255, then a small stamp
      for (int i = 0; i < 300; i++) begin
         if (8'(e + 4) == 8'hFF) break;
         step(1);
      end
      d_in = 1'b0;
      sb.push_back({1'b0, 8'hFF});
      step(6);
      chk("wrap_valid", out_valid, 1);
      chk("wrap_stamp", out_stamp, 8'hFF);
      step(2);
      d_in = 1'b1;
      sb.push_back({1'b1, 8'(e + 4)});
      step(6);
      chk("wrap_small_valid", out_valid, 1);
      chk("wrap_small", out_stamp < 8'd16, 1);
      step(2);

      // reset mid-debounce with two entries queued
      toggle(1'b0, 1'b1);
      out_ready = 1'b0;
      toggle(1'b1, 1'b1);
      toggle(1'b0, 1'b1);
      chk("rm_queued", dut.occ, 2);
      d_in = 1'b1;
      step(4);
      chk("rm_cnt", dut.cnt, 2);
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      sb.delete();
      sb.push_back({1'b1, 8'd4});
      chk("rm_valid", out_valid, 0);
      chk("rm_glitch", glitch_cnt, 0);
      chk("rm_ovf", overflow, 0);
      chk("rm_full", fifo_full, 0);
      step(5);
      chk("rm_early", out_valid, 0);
      step(1);
      chk("rm_evt_valid", out_valid, 1);
      chk("rm_evt_level", out_level, 1);
      chk("rm_evt_stamp", out_stamp, 4);
      out_ready = 1'b1;
      step(2);
      chk("sb_empty", sb.size(), 0);
      chk("final_empty", out_valid, 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
